// File: rtl/router_sync_n_pkg.sv
// ---------------------------------------------------------------------------
// router_sync_n_pkg
// Shared defaults for the parametrised router synchroniser. The top module,
// its bus interface and the per-port watchdog all take their default sizes
// from here so a single edit retunes the whole slice.
//
// Contents:
//   DEFAULT_NUM_PORTS  number of output FIFOs served by the router
//   DEFAULT_ADDR_W     width of the destination address field
//   DEFAULT_TIMEOUT    idle cycles before a port's soft reset pulse
//   DEFAULT_CNT_W      width of each watchdog idle counter
// ---------------------------------------------------------------------------
package router_sync_n_pkg;

  localparam int DEFAULT_NUM_PORTS = 3;
  localparam int DEFAULT_ADDR_W    = 2;
  localparam int DEFAULT_TIMEOUT   = 30;
  localparam int DEFAULT_CNT_W     = 5;

endpackage

// File: rtl/router_sync_n_if.sv
// ---------------------------------------------------------------------------
// router_sync_n_if
// Bundles every signal exchanged between the register block / FIFO bank and
// the router synchroniser. clk and rst are kept outside as plain ports.
//
// Modports:
//   master  drives detect_add, din, we_reg, wd_en, re, empty, full;
//           observes we, fifo_full, addr_err, vld_out, soft_rst
//   slave   the router itself (mirror image of master)
//
// Signals:
//   detect_add  1          header strobe, latch din as destination
//   din         ADDR_W     destination address
//   we_reg      1          write request for the current packet
//   wd_en       1          watchdog enable
//   re          NUM_PORTS  per-port FIFO read enable
//   empty       NUM_PORTS  per-port FIFO empty
//   full        NUM_PORTS  per-port FIFO full
//   we          NUM_PORTS  one-hot FIFO write enable
//   fifo_full   1          full flag of the addressed FIFO
//   addr_err    1          latched address is out of range
//   vld_out     NUM_PORTS  per-port valid (~empty)
//   soft_rst    NUM_PORTS  per-port one-cycle soft-reset pulse
// ---------------------------------------------------------------------------
interface router_sync_n_if
  import router_sync_n_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int ADDR_W    = DEFAULT_ADDR_W
);

  logic                 detect_add;
  logic [ADDR_W-1:0]    din;
  logic                 we_reg;
  logic                 wd_en;
  logic [NUM_PORTS-1:0] re;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] we;
  logic                 fifo_full;
  logic                 addr_err;
  logic [NUM_PORTS-1:0] vld_out;
  logic [NUM_PORTS-1:0] soft_rst;

  modport master (
    output detect_add, din, we_reg, wd_en, re, empty, full,
    input  we, fifo_full, addr_err, vld_out, soft_rst
  );

  modport slave (
    input  detect_add, din, we_reg, wd_en, re, empty, full,
    output we, fifo_full, addr_err, vld_out, soft_rst
  );

endinterface

// File: rtl/router_sync_n_wdt.sv
// ---------------------------------------------------------------------------
// router_sync_wdt
// Idle watchdog for one output port. Counts consecutive cycles in which the
// FIFO holds data but nobody reads it; after TIMEOUT such cycles it emits a
// one-cycle soft_rst pulse and starts counting again, so a FIFO that stays
// stuck is pulsed every TIMEOUT cycles.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous, active-low reset
//   en        in   watchdog enable; 0 holds the counter at zero
//   empty     in   FIFO empty flag for this port
//   re        in   FIFO read enable for this port (restarts the idle count)
//   soft_rst  out  registered one-cycle soft-reset pulse
// ---------------------------------------------------------------------------
module router_sync_wdt
  import router_sync_n_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic empty,
  input  logic re,
  output logic soft_rst
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Idle counter and pulse register. Anything that proves the port is alive
  // (empty, a read) or that the watchdog is off clears both. Reaching LAST
  // fires the pulse and wraps to zero, so the counter never runs past
  // TIMEOUT-1 and consecutive pulses are exactly TIMEOUT cycles apart.
  always_ff @(posedge clk) begin
    if (!rst || !en || empty || re) begin
      cnt      <= '0;
      soft_rst <= 1'b0;
    end else if (cnt == LAST) begin
      cnt      <= '0;
      soft_rst <= 1'b1;
    end else begin
      cnt      <= cnt + CNT_W'(1);
      soft_rst <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_n.sv
// ---------------------------------------------------------------------------
// router_sync_n
// Router synchroniser between the register block and NUM_PORTS output FIFOs.
// Latches the destination of each packet on its header, steers the write
// enable to that FIFO, returns that FIFO's full flag, flags out-of-range
// destinations and runs one idle watchdog per port.
//
// Ports:
//   clk   in      clock
//   rst   in      synchronous, active-low reset
//   bus   slave   router_sync_n_if bundle (see interface header)
// ---------------------------------------------------------------------------
module router_sync_n
  import router_sync_n_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  router_sync_n_if.slave  bus
);

  // Reject configurations the decode or the watchdog cannot represent.
  if (NUM_PORTS < 2 || NUM_PORTS > 4) begin : g_bad_ports
    $error("router_sync_n: NUM_PORTS must be in 2..4");
  end
  if (NUM_PORTS > (1 << ADDR_W)) begin : g_bad_addr_w
    $error("router_sync_n: ADDR_W too narrow for NUM_PORTS");
  end
  if (TIMEOUT < 2 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
    $error("router_sync_n: TIMEOUT must be in 2..2**CNT_W-1");
  end

  logic [ADDR_W-1:0]    addr_q;
  logic                 addr_err;
  logic [NUM_PORTS-1:0] we_c;
  logic                 fifo_full_c;
  logic [NUM_PORTS-1:0] soft_rst_w;

  // Destination latch. The header strobe captures the address and, on the
  // same edge, whether it points past the last port; both hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q   <= '0;
      addr_err <= 1'b0;
    end else if (bus.detect_add) begin
      addr_q   <= bus.din;
      addr_err <= (int'(bus.din) >= NUM_PORTS);
    end
  end

  // Write steering. Decodes the registered address, so a header arriving
  // together with we_reg still writes to the previous destination. A bad
  // address suppresses every write enable.
  always_comb begin
    we_c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      we_c[i] = bus.we_reg && !addr_err && (int'(addr_q) == i);
    end
  end

  // Back-pressure to the source. A bad address reports full so the source
  // stalls instead of pushing data nowhere.
  always_comb begin
    fifo_full_c = 1'b1;
    if (!addr_err) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (int'(addr_q) == i) fifo_full_c = bus.full[i];
      end
    end
  end

  assign bus.we        = we_c;
  assign bus.fifo_full = fifo_full_c;
  assign bus.addr_err  = addr_err;
  assign bus.vld_out   = ~bus.empty;
  assign bus.soft_rst  = soft_rst_w;

  // One independent idle watchdog per output port.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_wdt
    router_sync_wdt #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_wdt (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.wd_en),
      .empty    (bus.empty[i]),
      .re       (bus.re[i]),
      .soft_rst (soft_rst_w[i])
    );
  end

endmodule

// File: tb/tb_router_sync_n.sv
// ---------------------------------------------------------------------------
// tb_router_sync_n
// Drives a 3-port (TIMEOUT 30) and a 4-port (TIMEOUT 8) router from shared
// stimulus. Directed scenarios check against hand-derived constants; the
// random scenario checks against a behavioural model that tracks the latched
// destination and the number of idle cycles per port.
// ---------------------------------------------------------------------------
module tb_router_sync_n;

  localparam int TO3 = 30;
  localparam int TO4 = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  router_sync_n_if #(.NUM_PORTS(3), .ADDR_W(2)) if3 ();
  router_sync_n_if #(.NUM_PORTS(4), .ADDR_W(2)) if4 ();

  router_sync_n #(.NUM_PORTS(3), .ADDR_W(2), .TIMEOUT(TO3), .CNT_W(5)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  router_sync_n #(.NUM_PORTS(4), .ADDR_W(2), .TIMEOUT(TO4), .CNT_W(5)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  always #5 clk = ~clk;

  // Reference model: destination and error flag as last latched, plus a
  // plain count of idle cycles per port; a pulse is due whenever the idle
  // count is a non-zero multiple of the timeout.
  int         m_addr3 = 0;
  int         m_addr4 = 0;
  logic       m_err3  = 1'b0;
  int         idle3[3] = '{default: 0};
  int         idle4[4] = '{default: 0};
  logic [2:0] m_soft3 = '0;
  logic [3:0] m_soft4 = '0;

  always @(posedge clk) begin
    if (!rst) begin
      m_addr3 = 0;
      m_addr4 = 0;
      m_err3  = 1'b0;
      for (int i = 0; i < 3; i++) idle3[i] = 0;
      for (int i = 0; i < 4; i++) idle4[i] = 0;
      m_soft3 = '0;
      m_soft4 = '0;
    end else begin
      if (if3.detect_add) begin
        m_addr3 = int'(if3.din);
        m_err3  = (m_addr3 >= 3);
      end
      if (if4.detect_add) m_addr4 = int'(if4.din);
      for (int i = 0; i < 3; i++) begin
        if (!if3.wd_en || if3.empty[i] || if3.re[i]) begin
          idle3[i] = 0;
          m_soft3[i] = 1'b0;
        end else begin
          idle3[i] = idle3[i] + 1;
          m_soft3[i] = (idle3[i] % TO3 == 0);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!if4.wd_en || if4.empty[i] || if4.re[i]) begin
          idle4[i] = 0;
          m_soft4[i] = 1'b0;
        end else begin
          idle4[i] = idle4[i] + 1;
          m_soft4[i] = (idle4[i] % TO4 == 0);
        end
      end
    end
  end

  function automatic logic [2:0] exp_we3();
    logic [2:0] v;
    v = '0;
    if (if3.we_reg && !m_err3) v[m_addr3] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_ff3();
    if (m_err3) return 1'b1;
    return if3.full[m_addr3];
  endfunction

  function automatic logic [3:0] exp_we4();
    logic [3:0] v;
    v = '0;
    if (if4.we_reg) v[m_addr4] = 1'b1;
    return v;
  endfunction

  // Drives the same stimulus into both routers; the 3-port one sees the low bits.
  task automatic applyStimulus(input logic da, input logic [1:0] d, input logic wr,
                               input logic wd, input logic [3:0] r,
                               input logic [3:0] e, input logic [3:0] f);
    if3.detect_add = da;  if4.detect_add = da;
    if3.din        = d;   if4.din        = d;
    if3.we_reg     = wr;  if4.we_reg     = wr;
    if3.wd_en      = wd;  if4.wd_en      = wd;
    if3.re         = r[2:0];  if4.re     = r;
    if3.empty      = e[2:0];  if4.empty  = e;
    if3.full       = f[2:0];  if4.full   = f;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
    #1;
    tests_run++;
    if (if3.we !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_we: got %b expected 000", if3.we);
    end
    tests_run++;
    if (if3.soft_rst !== 3'b000 || if4.soft_rst !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_soft_rst: got %b/%b expected 000/0000", if3.soft_rst, if4.soft_rst);
    end
    tests_run++;
    if (if3.addr_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_addr_err: got %b expected 0", if3.addr_err);
    end
    tests_run++;
    if (if3.vld_out !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_vld_out: got %b expected 000", if3.vld_out);
    end
    tests_run++;
    if (if3.fifo_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_fifo_full: got %b expected 0", if3.fifo_full);
    end
  endtask

  task automatic test_addr_decode();
    @(negedge clk);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 4'h0, 4'hF, 4'b0100);
    #1;
    tests_run++;
    if (if3.we !== 3'b100 || if3.fifo_full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL decode_port2: got we=%b full=%b expected we=100 full=1", if3.we, if3.fifo_full);
    end
    tests_run++;
    if (if4.we !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL decode_port2_n4: got %b expected 0100", if4.we);
    end
    // header and write in the same cycle: write still goes to the old port
    @(negedge clk);
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b1, 4'h0, 4'hF, 4'b0100);
    #1;
    tests_run++;
    if (if3.we !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL decode_same_cycle: got %b expected 100", if3.we);
    end
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 4'h0, 4'b1010, 4'b0100);
    #1;
    tests_run++;
    if (if3.we !== 3'b010 || if3.fifo_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL decode_port1: got we=%b full=%b expected we=010 full=0", if3.we, if3.fifo_full);
    end
    tests_run++;
    if (if3.vld_out !== 3'b101 || if4.vld_out !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL vld_out: got %b/%b expected 101/0101", if3.vld_out, if4.vld_out);
    end
  endtask

  task automatic test_addr_err();
    @(negedge clk);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 4'h0, 4'hF, 4'h0);
    #1;
    tests_run++;
    if (if3.addr_err !== 1'b1 || if3.we !== 3'b000 || if3.fifo_full !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL addr_err_set: got err=%b we=%b full=%b expected err=1 we=000 full=1",
               if3.addr_err, if3.we, if3.fifo_full);
    end
    tests_run++;
    if (if4.addr_err !== 1'b0 || if4.we !== 4'b1000) begin
      tests_failed++;
      $display("[TB] FAIL addr3_valid_n4: got err=%b we=%b expected err=0 we=1000", if4.addr_err, if4.we);
    end
    @(negedge clk);
    applyStimulus(1'b1, 2'd0, 1'b1, 1'b1, 4'h0, 4'hF, 4'h0);
    #1;
    tests_run++;
    if (if3.addr_err !== 1'b1 || if3.we !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL addr_err_hold: got err=%b we=%b expected err=1 we=000", if3.addr_err, if3.we);
    end
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 4'h0, 4'hF, 4'h0);
    #1;
    tests_run++;
    if (if3.addr_err !== 1'b0 || if3.we !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL addr_err_clear: got err=%b we=%b expected err=0 we=001", if3.addr_err, if3.we);
    end
  endtask

  task automatic test_watchdog();
    logic [2:0] exp;
    // run 1: port 0 idle throughout, pulses at 30 and 60
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'b1110, 4'h0);
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      #1;
      exp = (c == 30 || c == 60) ? 3'b001 : 3'b000;
      tests_run++;
      if (if3.soft_rst !== exp) begin
        tests_failed++;
        $display("[TB] FAIL wdt_idle c=%0d: got %b expected %b", c, if3.soft_rst, exp);
      end
    end
    // run 2: a read at cycle 20 moves the pulse to cycle 50
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'b1110, 4'h0);
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      #1;
      exp = (c == 50) ? 3'b001 : 3'b000;
      tests_run++;
      if (if3.soft_rst !== exp) begin
        tests_failed++;
        $display("[TB] FAIL wdt_read_restart c=%0d: got %b expected %b", c, if3.soft_rst, exp);
      end
      applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, (c == 19) ? 4'h1 : 4'h0, 4'b1110, 4'h0);
    end
  endtask

  task automatic test_wd_enable();
    logic [2:0] exp;
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'b1100, 4'h0);
    for (int c = 1; c <= 75; c++) begin
      @(negedge clk);
      #1;
      exp = (c == 70) ? 3'b011 : 3'b000;
      tests_run++;
      if (if3.soft_rst !== exp) begin
        tests_failed++;
        $display("[TB] FAIL wdt_enable c=%0d: got %b expected %b", c, if3.soft_rst, exp);
      end
      applyStimulus(1'b0, 2'd0, 1'b0, !(c >= 9 && c < 40), 4'h0, 4'b1100, 4'h0);
    end
  endtask

  task automatic test_reset_midcount();
    logic [2:0] exp;
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'b1110, 4'h0);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      #1;
      exp = (c == 56) ? 3'b001 : 3'b000;
      tests_run++;
      if (if3.soft_rst !== exp) begin
        tests_failed++;
        $display("[TB] FAIL wdt_reset_mid c=%0d: got %b expected %b", c, if3.soft_rst, exp);
      end
      rst = (c == 25) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_timeout8();
    logic [3:0] exp;
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'hF, 4'h0);
    @(negedge clk);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 4'h0, 4'b0111, 4'h0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      #1;
      exp = (c == 8 || c == 16) ? 4'b1000 : 4'b0000;
      tests_run++;
      if (if4.soft_rst !== exp) begin
        tests_failed++;
        $display("[TB] FAIL wdt_n4_t8 c=%0d: got %b expected %b", c, if4.soft_rst, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r, e, f;
    logic [10:0] act3, exp3;
    logic [13:0] act4, exp4;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      rst = ($urandom_range(127) != 0);
      for (int i = 0; i < 4; i++) begin
        r[i] = ($urandom_range(31) == 0);
        e[i] = ($urandom_range(31) == 0);
      end
      f = 4'($urandom_range(15));
      applyStimulus($urandom_range(3) == 0, 2'($urandom_range(3)), 1'($urandom_range(1)),
                    $urandom_range(63) != 0, r, e, f);
      #1;
      act3 = {if3.we, if3.fifo_full, if3.addr_err, if3.vld_out, if3.soft_rst};
      exp3 = {exp_we3(), exp_ff3(), m_err3, ~e[2:0], m_soft3};
      tests_run++;
      if (act3 !== exp3) begin
        tests_failed++;
        $display("[TB] FAIL random_n3 n=%0d: got %b expected %b (we,full,err,vld,soft)", n, act3, exp3);
      end
      act4 = {if4.we, if4.fifo_full, if4.addr_err, if4.vld_out, if4.soft_rst};
      exp4 = {exp_we4(), if4.full[m_addr4], 1'b0, ~e, m_soft4};
      tests_run++;
      if (act4 !== exp4) begin
        tests_failed++;
        $display("[TB] FAIL random_n4 n=%0d: got %b expected %b (we,full,err,vld,soft)", n, act4, exp4);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'hF, 4'h0);
    test_reset();
    test_addr_decode();
    test_addr_err();
    test_watchdog();
    test_wd_enable();
    test_reset_midcount();
    test_timeout8();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
